// File: rtl/fifo_pkg.sv
// Shared definitions for the byte FIFO and the blocks that consume its byte stream.
package fifo_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_SEND = 1'b1
    } state_t;

endpackage

// File: rtl/fifo_word_packer.sv
// Pops bytes from the byte FIFO and packs them little-endian into BYTES-wide words on a
// valid/ready stream; a flush emits the current partial word with a lane-keep mask.
module fifo_word_packer
    import fifo_pkg::*;
#(
    parameter int unsigned BYTES = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fifo_empty,
    output logic                     fifo_rd_en,
    input  logic [BYTE_W-1:0]        fifo_data,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BYTE_W*BYTES-1:0]  out_data,
    output logic [BYTES-1:0]         out_keep
);

    localparam int unsigned CNT_W = $clog2(BYTES + 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] count;
    logic             inflight;
    logic             flush_pend;
    logic [BYTES-1:0] keep_q;
    logic [BYTES-1:0] part_keep;
    logic [CNT_W:0]   occupancy;
    logic             capture, last_byte, flush_go, flush_drop, handshake;

    assign occupancy  = {1'b0, count} + (CNT_W + 1)'(inflight);
    assign capture    = (state == ST_FILL) && inflight;
    assign last_byte  = capture && (count == CNT_W'(BYTES - 1));
    assign flush_go   = (state == ST_FILL) && !inflight && flush_pend && (count != '0);
    assign flush_drop = (state == ST_FILL) && !inflight && flush_pend && (count == '0);
    assign handshake  = (state == ST_SEND) && out_ready;

    always_ff @(posedge clk) begin
        if (reset) state <= ST_FILL;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_FILL: if (last_byte || flush_go) state_nxt = ST_SEND;
            ST_SEND: if (out_ready)             state_nxt = ST_FILL;
            default:                            state_nxt = ST_FILL;
        endcase
    end

    // A pop is withheld in the flush-service cycle, otherwise its byte would land during SEND.
    always_comb begin
        fifo_rd_en = 1'b0;
        out_valid  = 1'b0;
        if (!reset) begin
            out_valid  = (state == ST_SEND);
            fifo_rd_en = (state == ST_FILL) && !fifo_empty &&
                         (occupancy < (CNT_W + 1)'(BYTES)) && !flush_go;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count      <= '0;
            inflight   <= 1'b0;
            flush_pend <= 1'b0;
            keep_q     <= '0;
        end else begin
            inflight <= fifo_rd_en;
            if (flush)                        flush_pend <= 1'b1;
            else if (flush_go || flush_drop)  flush_pend <= 1'b0;
            if (handshake) begin
                count  <= '0;
                keep_q <= '0;
            end else if (capture) begin
                count <= count + 1'b1;
                if (last_byte) keep_q <= '1;
            end else if (flush_go) begin
                keep_q <= part_keep;
            end
        end
    end

    for (genvar k = 0; k < BYTES; k++) begin : g_lane
        logic [BYTE_W-1:0] lane_q;

        always_ff @(posedge clk) begin
            if (reset || handshake)                     lane_q <= '0;
            else if (capture && count == CNT_W'(k))     lane_q <= fifo_data;
        end

        assign part_keep[k]                = (count > CNT_W'(k));
        assign out_data[BYTE_W*k +: BYTE_W] = out_valid ? lane_q : '0;
        assign out_keep[k]                 = out_valid & keep_q[k];
    end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Self-checking bench for fifo_word_packer: directed scenarios plus randomized traffic
// checked against a byte-queue reference model.
module tb_fifo_word_packer;

    localparam int unsigned BYTES = 4;

    logic               clk = 1'b0;
    logic               reset, fifo_empty, fifo_rd_en, flush, out_valid, out_ready;
    logic [7:0]         fifo_data;
    logic [8*BYTES-1:0] out_data;
    logic [BYTES-1:0]   out_keep;

    always #5 clk = ~clk;

    fifo_word_packer #(.BYTES(BYTES)) dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_data  (fifo_data),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_keep   (out_keep)
    );

    int unsigned checks = 0;
    int unsigned failures = 0;

    byte unsigned       src_q[$];     // bytes still held in the FIFO
    byte unsigned       popped_q[$];  // popped but not yet accepted downstream
    logic [8*BYTES-1:0] words_q[$];
    logic [BYTES-1:0]   keeps_q[$];
    logic               pop_pending;
    byte unsigned       pop_byte;
    logic               flush_seen;
    int                 cyc, rd_cnt, valid_cnt, first_rd, last_rd, first_valid;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        rd_cnt = 0; valid_cnt = 0; first_rd = -1; last_rd = -1; first_valid = -1;
        words_q.delete(); keeps_q.delete();
    endtask

    // One clock: drive inputs after the falling edge, then check the settled outputs.
    task automatic step(input logic fl, input logic rdy, input logic starve);
        int unsigned        n;
        logic [63:0]        exp_data;
        logic [63:0]        exp_keep;
        @(negedge clk);
        fifo_data  = pop_pending ? pop_byte : 8'($urandom);
        fifo_empty = starve || (src_q.size() == 0);
        flush      = fl;
        out_ready  = rdy;
        #1;
        if (fifo_empty) check_eq("rd_en_while_empty", 64'(fifo_rd_en), 64'd0);
        if (out_valid) begin
            check_eq("rd_en_in_send", 64'(fifo_rd_en), 64'd0);
            n = (popped_q.size() > BYTES) ? BYTES : popped_q.size();
            exp_data = '0;
            for (int unsigned i = 0; i < n; i++) exp_data[8*i +: 8] = popped_q[i];
            exp_keep = (64'd1 << n) - 64'd1;
            if (n < BYTES) check_eq("partial_needs_flush", 64'(flush_seen), 64'd1);
            check_eq("out_data", 64'(out_data), exp_data);
            check_eq("out_keep", 64'(out_keep), exp_keep);
            if (first_valid < 0) first_valid = cyc;
            valid_cnt++;
            if (rdy) begin
                for (int unsigned i = 0; i < n; i++) void'(popped_q.pop_front());
                words_q.push_back(out_data);
                keeps_q.push_back(out_keep);
                if (n < BYTES) flush_seen = 1'b0;
            end
        end
        if (fl) flush_seen = 1'b1;
        pop_pending = fifo_rd_en;
        if (fifo_rd_en && src_q.size() != 0) begin
            pop_byte = src_q.pop_front();
            popped_q.push_back(pop_byte);
            rd_cnt++;
            if (first_rd < 0) first_rd = cyc;
            last_rd = cyc;
        end
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; flush = 1'b0; out_ready = 1'b1; fifo_empty = 1'b0;
        #1;
        check_eq("rst_rd_en", 64'(fifo_rd_en), 64'd0);
        check_eq("rst_valid", 64'(out_valid), 64'd0);
        check_eq("rst_data", 64'(out_data), 64'd0);
        check_eq("rst_keep", 64'(out_keep), 64'd0);
        @(negedge clk);
        reset = 1'b0; fifo_empty = 1'b1;
        src_q.delete(); popped_q.delete();
        pop_pending = 1'b0; flush_seen = 1'b0;
        #1;
        check_eq("post_rst_valid", 64'(out_valid), 64'd0);
        cyc++;
    endtask

    task automatic wait_valid(input int unsigned budget);
        int unsigned k = 0;
        do begin
            step(1'b0, 1'b0, 1'b0);
            k++;
        end while (!out_valid && k < budget);
        check_eq("wait_valid_timeout", 64'(out_valid), 64'd1);
    endtask

    initial begin
        reset = 1'b1; fifo_empty = 1'b1; flush = 1'b0; out_ready = 1'b0; fifo_data = '0;
        pop_pending = 1'b0; flush_seen = 1'b0; cyc = 0;
        clear_stats();
        do_reset();

        // 1: basic word, latency and consecutive pops
        clear_stats();
        src_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        repeat (8) step(1'b0, 1'b1, 1'b0);
        check_eq("t1_rd_cnt", 64'(rd_cnt), 64'd4);
        check_eq("t1_rd_span", 64'(last_rd - first_rd), 64'd3);
        check_eq("t1_latency", 64'(first_valid - last_rd), 64'd2);
        check_eq("t1_valid_cycles", 64'(valid_cnt), 64'd1);
        check_eq("t1_words", 64'(words_q.size()), 64'd1);
        if (words_q.size() > 0) begin
            check_eq("t1_word", 64'(words_q[0]), 64'h44332211);
            check_eq("t1_keep", 64'(keeps_q[0]), 64'hF);
        end

        // 2: backpressure holds the word, no pops while sending
        clear_stats();
        for (int i = 0; i < 8; i++) src_q.push_back(8'(8'hA0 + i));
        wait_valid(20);
        repeat (4) step(1'b0, 1'b0, 1'b0);
        repeat (12) step(1'b0, 1'b1, 1'b0);
        check_eq("t2_valid_cycles", 64'(valid_cnt), 64'd7);
        check_eq("t2_words", 64'(words_q.size()), 64'd2);
        if (words_q.size() > 1) begin
            check_eq("t2_word0", 64'(words_q[0]), 64'hA3A2A1A0);
            check_eq("t2_word1", 64'(words_q[1]), 64'hA7A6A5A4);
        end

        // 3: flush of a partial word, next word restarts at lane 0
        clear_stats();
        src_q = '{8'h55, 8'h66};
        repeat (4) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        repeat (6) step(1'b0, 1'b1, 1'b0);
        src_q = '{8'h77, 8'h88, 8'h99, 8'hAA};
        repeat (8) step(1'b0, 1'b1, 1'b0);
        check_eq("t3_words", 64'(words_q.size()), 64'd2);
        if (words_q.size() > 1) begin
            check_eq("t3_word0", 64'(words_q[0]), 64'h00006655);
            check_eq("t3_keep0", 64'(keeps_q[0]), 64'h3);
            check_eq("t3_word1", 64'(words_q[1]), 64'hAA998877);
            check_eq("t3_keep1", 64'(keeps_q[1]), 64'hF);
        end

        // 4: flush with nothing captured emits nothing and leaves no pending flush behind
        clear_stats();
        step(1'b1, 1'b1, 1'b0);
        repeat (6) step(1'b0, 1'b1, 1'b0);
        check_eq("t4_valid_cycles", 64'(valid_cnt), 64'd0);
        check_eq("t4_rd_cnt", 64'(rd_cnt), 64'd0);
        flush_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            src_q.push_back(8'(8'hB1 + i));
            repeat (4) step(1'b0, 1'b1, 1'b0);
        end
        repeat (3) step(1'b0, 1'b1, 1'b0);
        check_eq("t4_words", 64'(words_q.size()), 64'd1);
        if (words_q.size() > 0) begin
            check_eq("t4_word", 64'(words_q[0]), 64'hB4B3B2B1);
            check_eq("t4_keep", 64'(keeps_q[0]), 64'hF);
        end

        // 5: empty flag toggling every cycle
        clear_stats();
        src_q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
        for (int i = 0; i < 14; i++) step(1'b0, 1'b1, 1'(i % 2));
        check_eq("t5_words", 64'(words_q.size()), 64'd1);
        if (words_q.size() > 0) check_eq("t5_word", 64'(words_q[0]), 64'hC4C3C2C1);

        // 6: reset mid-word discards captured bytes
        clear_stats();
        src_q = '{8'hE1, 8'hE2};
        repeat (4) step(1'b0, 1'b1, 1'b0);
        do_reset();
        src_q = '{8'hD1, 8'hD2, 8'hD3, 8'hD4};
        repeat (8) step(1'b0, 1'b1, 1'b0);
        check_eq("t6_words", 64'(words_q.size()), 64'd1);
        if (words_q.size() > 0) begin
            check_eq("t6_word", 64'(words_q[0]), 64'hD4D3D2D1);
            check_eq("t6_keep", 64'(keeps_q[0]), 64'hF);
        end

        // Randomized traffic against the byte-queue model
        clear_stats();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 2) == 0 && src_q.size() < 16) src_q.push_back(8'($urandom));
            if ($urandom_range(0, 299) == 0) do_reset();
            else step(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 3) == 0));
        end
        repeat (40) step(1'b0, 1'b1, 1'b0);
        check_eq("rand_words_seen", 64'(words_q.size() > 0), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
